// File: rtl/note_sequencer_pkg.sv
// Shared definitions for the melody sequencer: waveform codes, song-table field layout,
// sequencer states and the duration decode helper.
package note_sequencer_pkg;

   typedef enum logic [1:0] {
      FormSin = 2'd0,
      FormTri = 2'd1,
      FormSq  = 2'd2
   } form_e;

   localparam int unsigned ENTRY_W = 11;
   localparam int unsigned END_B   = 10;
   localparam int unsigned REST_B  = 9;
   localparam int unsigned FID_MSB = 8;
   localparam int unsigned FID_LSB = 4;
   localparam int unsigned DUR_MSB = 3;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StDecode,
      StPlay,
      StGap
   } seq_state_e;

   // A stored duration of 0 encodes the longest note, 16 ticks.
   function automatic logic [4:0] dur_ticks(input logic [DUR_MSB:0] dur);
      return (dur == '0) ? 5'd16 : {1'b0, dur};
   endfunction

endpackage

// File: rtl/note_sequencer_song_rom.sv
// Synchronous song table: one 11-bit entry per address, 1-cycle read latency.
// Contents arrive as a flat parameter, entry 0 in the least significant bits.
module note_sequencer_song_rom
   import note_sequencer_pkg::*;
#(
   parameter int unsigned                           ADDR_BITS = 6,
   parameter logic [ENTRY_W*(2**ADDR_BITS)-1:0]     CONTENTS  = '0
) (
   input  logic                 i_clock,
   input  logic [ADDR_BITS-1:0] i_addr,
   output logic [ENTRY_W-1:0]   o_data
);

   logic [ENTRY_W-1:0] w_table [2**ADDR_BITS];
   logic [ENTRY_W-1:0] r_data;

   for (genvar g = 0; g < 2**ADDR_BITS; g++) begin : g_tbl
      assign w_table[g] = CONTENTS[g*ENTRY_W +: ENTRY_W];
   end

   always_ff @(posedge i_clock) begin
      r_data <= w_table[i_addr];
   end

   assign o_data = r_data;

endmodule

// File: rtl/note_sequencer.sv
// Melody player: walks the song table and feeds freq_id/new_f/form to the waveform
// generator, with a gate that is low during rests and the articulation gap.
module note_sequencer
   import note_sequencer_pkg::*;
#(
   parameter int unsigned                           TICK_DIV  = 1625000,
   parameter int unsigned                           GAP_CYC   = 65000,
   parameter int unsigned                           ADDR_BITS = 6,
   parameter logic [ENTRY_W*(2**ADDR_BITS)-1:0]     SONG      = '0
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   input  logic                 i_start,
   input  logic                 i_stop,
   input  logic                 i_loop,
   input  logic [1:0]           i_form_sel,
   output logic [4:0]           o_freq_id,
   output logic                 o_new_f,
   output logic [1:0]           o_form,
   output logic                 o_gate,
   output logic                 o_playing,
   output logic [ADDR_BITS-1:0] o_note_addr
);

   localparam int unsigned PRE_W = $clog2(TICK_DIV);
   localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);
   localparam logic [PRE_W-1:0]     PRE_LAST  = PRE_W'(TICK_DIV - 1);
   localparam logic [GAP_W-1:0]     GAP_LAST  = GAP_W'(GAP_CYC - 1);
   localparam logic [ADDR_BITS-1:0] ADDR_LAST = '1;

   seq_state_e           r_state, w_state_nxt;
   logic [ADDR_BITS-1:0] r_addr, w_addr_nxt;
   logic [4:0]           r_fid, w_fid_nxt;
   form_e                r_form, w_form_nxt;
   logic                 r_new_f, w_new_f_nxt;
   logic                 r_gate, w_gate_nxt;
   logic                 r_playing, w_playing_nxt;
   logic [PRE_W-1:0]     r_pre, w_pre_nxt;
   logic [4:0]           r_ticks, w_ticks_nxt;
   logic [GAP_W-1:0]     r_gap, w_gap_nxt;
   logic [ENTRY_W-1:0]   w_entry;
   logic                 w_end;

   note_sequencer_song_rom #(
      .ADDR_BITS (ADDR_BITS),
      .CONTENTS  (SONG)
   ) u_rom (
      .i_clock (i_clock),
      .i_addr  (r_addr),
      .o_data  (w_entry)
   );

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state   <= StIdle;
         r_addr    <= '0;
         r_fid     <= '0;
         r_form    <= FormSin;
         r_new_f   <= 1'b0;
         r_gate    <= 1'b0;
         r_playing <= 1'b0;
         r_pre     <= '0;
         r_ticks   <= '0;
         r_gap     <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_addr    <= w_addr_nxt;
         r_fid     <= w_fid_nxt;
         r_form    <= w_form_nxt;
         r_new_f   <= w_new_f_nxt;
         r_gate    <= w_gate_nxt;
         r_playing <= w_playing_nxt;
         r_pre     <= w_pre_nxt;
         r_ticks   <= w_ticks_nxt;
         r_gap     <= w_gap_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_addr_nxt    = r_addr;
      w_fid_nxt     = r_fid;
      w_form_nxt    = r_form;
      w_new_f_nxt   = 1'b0;
      w_gate_nxt    = r_gate;
      w_playing_nxt = r_playing;
      w_pre_nxt     = r_pre;
      w_ticks_nxt   = r_ticks;
      w_gap_nxt     = r_gap;
      w_end         = 1'b0;

      if (i_stop) begin
         w_state_nxt   = StIdle;
         w_gate_nxt    = 1'b0;
         w_playing_nxt = 1'b0;
      end else if (i_start) begin
         w_state_nxt   = StFetch;
         w_addr_nxt    = '0;
         w_gate_nxt    = 1'b0;
         w_playing_nxt = 1'b1;
      end else begin
         case (r_state)
            StIdle: ;
            StFetch: w_state_nxt = StDecode;
            StDecode: begin
               if (w_entry[END_B]) begin
                  w_end = 1'b1;
               end else begin
                  w_ticks_nxt = dur_ticks(w_entry[DUR_MSB:0]);
                  w_pre_nxt   = '0;
                  w_state_nxt = StPlay;
                  if (!w_entry[REST_B]) begin
                     w_fid_nxt   = w_entry[FID_MSB:FID_LSB];
                     w_form_nxt  = form_e'(i_form_sel);
                     w_new_f_nxt = 1'b1;
                     w_gate_nxt  = 1'b1;
                  end
               end
            end
            StPlay: begin
               if (r_pre == PRE_LAST) begin
                  w_pre_nxt = '0;
                  if (r_ticks == 5'd1) begin
                     w_gate_nxt  = 1'b0;
                     w_gap_nxt   = '0;
                     w_state_nxt = StGap;
                  end else begin
                     w_ticks_nxt = r_ticks - 5'd1;
                  end
               end else begin
                  w_pre_nxt = r_pre + PRE_W'(1);
               end
            end
            StGap: begin
               if (r_gap == GAP_LAST) begin
                  // Running off the end of the table behaves like an end entry.
                  if (r_addr == ADDR_LAST) begin
                     w_end = 1'b1;
                  end else begin
                     w_addr_nxt  = r_addr + ADDR_BITS'(1);
                     w_state_nxt = StFetch;
                  end
               end else begin
                  w_gap_nxt = r_gap + GAP_W'(1);
               end
            end
            default: w_state_nxt = StIdle;
         endcase

         if (w_end) begin
            if (i_loop) begin
               w_addr_nxt  = '0;
               w_state_nxt = StFetch;
            end else begin
               w_state_nxt   = StIdle;
               w_playing_nxt = 1'b0;
            end
         end
      end
   end

   assign o_freq_id   = r_fid;
   assign o_new_f     = r_new_f;
   assign o_form      = r_form;
   assign o_gate      = r_gate;
   assign o_playing   = r_playing;
   assign o_note_addr = r_addr;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with a short tick/gap so whole songs fit in a few
// hundred cycles; per-cycle captures are compared against hand-computed windows.
module tb_note_sequencer;

   // Song A: 0:{fid 12, dur 2} 1:{rest, dur 1} 2:{end}
   localparam logic [703:0] SONG_A = {{61{11'h000}}, 11'h400, 11'h201, 11'h0C2};
   // Song B: 0:{fid 5, dur 0} then 63 one-tick rests, no end entry
   localparam logic [703:0] SONG_B = {{63{11'h201}}, 11'h050};
   localparam int CAP = 600;

   logic       clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, loop = 1'b0;
   logic [1:0] form_sel = 2'd0;
   logic [4:0] a_fid, b_fid;
   logic       a_nf, b_nf, a_g, b_g, a_p, b_p;
   logic [1:0] a_form, b_form;
   logic [5:0] a_addr, b_addr;

   note_sequencer #(.TICK_DIV(4), .GAP_CYC(2), .ADDR_BITS(6), .SONG(SONG_A)) dut_a (
      .i_clock (clk), .i_reset (rst), .i_start (start), .i_stop (stop), .i_loop (loop),
      .i_form_sel (form_sel), .o_freq_id (a_fid), .o_new_f (a_nf), .o_form (a_form),
      .o_gate (a_g), .o_playing (a_p), .o_note_addr (a_addr)
   );

   note_sequencer #(.TICK_DIV(4), .GAP_CYC(2), .ADDR_BITS(6), .SONG(SONG_B)) dut_b (
      .i_clock (clk), .i_reset (rst), .i_start (start), .i_stop (stop), .i_loop (loop),
      .i_form_sel (form_sel), .o_freq_id (b_fid), .o_new_f (b_nf), .o_form (b_form),
      .o_gate (b_g), .o_playing (b_p), .o_note_addr (b_addr)
   );

   always #5 clk = ~clk;

   typedef struct {
      string name;
      int    lo, hi, nf, g, p, addr, fid, form;
   } vec_t;

   vec_t vecs[$];
   int   cap_nf[CAP], cap_g[CAP], cap_p[CAP], cap_addr[CAP], cap_fid[CAP], cap_form[CAP];
   int   cur = 0, total = 0, bad = 0;
   bit   sel_b = 1'b0;

   function automatic void add(string n, int lo, int hi, int nf, int g, int p, int addr,
                               int fid, int form);
      vec_t v;
      v.name = n; v.lo = lo; v.hi = hi; v.nf = nf; v.g = g; v.p = p;
      v.addr = addr; v.fid = fid; v.form = form;
      vecs.push_back(v);
   endfunction

   // One clock cycle: inputs for cycle 'cur' applied, outputs of cycle 'cur' captured.
   task automatic cyc(input logic st, input logic sp);
      @(posedge clk);
      #1;
      start = st;
      stop  = sp;
      if (cur < CAP) begin
         cap_nf[cur]   = sel_b ? int'(b_nf)   : int'(a_nf);
         cap_g[cur]    = sel_b ? int'(b_g)    : int'(a_g);
         cap_p[cur]    = sel_b ? int'(b_p)    : int'(a_p);
         cap_addr[cur] = sel_b ? int'(b_addr) : int'(a_addr);
         cap_fid[cur]  = sel_b ? int'(b_fid)  : int'(a_fid);
         cap_form[cur] = sel_b ? int'(b_form) : int'(a_form);
      end
      cur++;
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      start = 1'b0;
      stop  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      cur = 0;
   endtask

   task automatic check_vecs();
      foreach (vecs[i]) begin
         int bc;
         bc = -1;
         for (int c = vecs[i].lo; c <= vecs[i].hi; c++) begin
            if (cap_nf[c] != vecs[i].nf || cap_g[c] != vecs[i].g || cap_p[c] != vecs[i].p ||
                cap_addr[c] != vecs[i].addr || cap_fid[c] != vecs[i].fid ||
                cap_form[c] != vecs[i].form) begin
               bc = c;
               break;
            end
         end
         total++;
         if (bc >= 0) begin
            bad++;
            $display("FAIL %s cycle %0d: got nf=%0d gate=%0d play=%0d addr=%0d fid=%0d form=%0d, want nf=%0d gate=%0d play=%0d addr=%0d fid=%0d form=%0d",
                     vecs[i].name, bc, cap_nf[bc], cap_g[bc], cap_p[bc], cap_addr[bc],
                     cap_fid[bc], cap_form[bc], vecs[i].nf, vecs[i].g, vecs[i].p,
                     vecs[i].addr, vecs[i].fid, vecs[i].form);
         end
      end
      vecs.delete();
   endtask

   initial begin
      int nf_count;

      // Basic song, no loop
      sel_b = 1'b0; loop = 1'b0; form_sel = 2'd2;
      do_reset();
      for (int i = 0; i <= 30; i++) cyc(i == 0, 1'b0);
      add("idle_reset", 0, 0, 0, 0, 0, 0, 0, 0);
      add("fetch_decode", 1, 2, 0, 0, 1, 0, 0, 0);
      add("note_on", 3, 3, 1, 1, 1, 0, 12, 2);
      add("note_hold", 4, 10, 0, 1, 1, 0, 12, 2);
      add("gap0", 11, 12, 0, 0, 1, 0, 12, 2);
      add("rest", 13, 20, 0, 0, 1, 1, 12, 2);
      add("end_fetch", 21, 22, 0, 0, 1, 2, 12, 2);
      add("idle_end", 23, 30, 0, 0, 0, 2, 12, 2);
      check_vecs();

      // Loop; form_sel changed mid-note only affects the next note
      loop = 1'b1; form_sel = 2'd2;
      do_reset();
      for (int i = 0; i <= 34; i++) begin
         if (i == 5) form_sel = 2'd1;
         cyc(i == 0, 1'b0);
      end
      add("loop_first", 3, 3, 1, 1, 1, 0, 12, 2);
      add("loop_midform", 4, 10, 0, 1, 1, 0, 12, 2);
      add("loop_end", 21, 22, 0, 0, 1, 2, 12, 2);
      add("loop_refetch", 23, 24, 0, 0, 1, 0, 12, 2);
      add("loop_second", 25, 25, 1, 1, 1, 0, 12, 1);
      add("loop_hold2", 26, 32, 0, 1, 1, 0, 12, 1);
      check_vecs();

      // Stop mid-note, then start+stop together from idle
      loop = 1'b0; form_sel = 2'd2;
      do_reset();
      for (int i = 0; i <= 20; i++) cyc(i == 0 || i == 13, i == 6 || i == 13);
      add("pre_stop", 4, 6, 0, 1, 1, 0, 12, 2);
      add("stopped", 7, 12, 0, 0, 0, 0, 12, 2);
      add("start_stop_idle", 14, 20, 0, 0, 0, 0, 12, 2);
      check_vecs();

      // Restart while playing
      do_reset();
      for (int i = 0; i <= 20; i++) cyc(i == 0 || i == 8, 1'b0);
      add("restart_g0", 9, 10, 0, 0, 1, 0, 12, 2);
      add("restart_nf", 11, 11, 1, 1, 1, 0, 12, 2);
      add("restart_hold", 12, 18, 0, 1, 1, 0, 12, 2);
      add("restart_gap", 19, 20, 0, 0, 1, 0, 12, 2);
      check_vecs();

      // Asynchronous reset mid-PLAY
      do_reset();
      for (int i = 0; i <= 5; i++) cyc(i == 0, 1'b0);
      add("pre_rst_gate", 4, 5, 0, 1, 1, 0, 12, 2);
      check_vecs();
      #2;
      rst = 1'b1;
      #1;
      total++;
      if ({a_g, a_nf, a_p, a_fid, a_form, a_addr} !== 16'd0) begin
         bad++;
         $display("FAIL async_reset: got gate=%0d nf=%0d play=%0d fid=%0d form=%0d addr=%0d, want all 0",
                  a_g, a_nf, a_p, a_fid, a_form, a_addr);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      cur = 0;
      for (int i = 0; i <= 5; i++) cyc(i == 0, 1'b0);
      add("rst_lat_wait", 1, 2, 0, 0, 1, 0, 0, 0);
      add("rst_lat_on", 3, 3, 1, 1, 1, 0, 12, 2);
      check_vecs();

      // dur=0 note (16 ticks) and a full table with no end entry
      sel_b = 1'b1; form_sel = 2'd0; loop = 1'b0;
      do_reset();
      for (int i = 0; i <= 580; i++) cyc(i == 0, 1'b0);
      add("b_on", 3, 3, 1, 1, 1, 0, 5, 0);
      add("b_hold64", 4, 66, 0, 1, 1, 0, 5, 0);
      add("b_gap", 67, 68, 0, 0, 1, 0, 5, 0);
      add("b_addr1", 69, 76, 0, 0, 1, 1, 5, 0);
      add("b_addr63", 565, 572, 0, 0, 1, 63, 5, 0);
      add("b_idle", 573, 580, 0, 0, 0, 63, 5, 0);
      check_vecs();
      nf_count = 0;
      for (int c = 0; c <= 580; c++) nf_count += cap_nf[c];
      total++;
      if (nf_count != 1) begin
         bad++;
         $display("FAIL b_new_f_count: got %0d pulses, want 1", nf_count);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
